// File: rtl/fifo_flow_flags.sv
// Synchronous FIFO feeding the flow-control FSM: stores producer words, returns them
// with one-cycle registered read latency, and reports occupancy flags and drop events.
module fifo_flow_flags #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 2,
  parameter int ALMOST_FULL_TH  = 3,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  wr_en_s, rd_en_s;

  // Accept decisions, next-state pointers/count, and flags decoded from the next count
  always_comb begin
    // A pop at full frees a slot, so the concurrent push is still accepted
    wr_en_s = push && (!full_q || pop);
    rd_en_s = pop && !empty_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overflow_d     = push && full_q && !pop;
    underflow_d    = pop && empty_q;
    full_d         = (count_d == DEPTH_C);
    almost_full_d  = (count_d >= AF_TH_C) && (count_d < DEPTH_C);
    empty_d        = (count_d == {CW{1'b0}});
    almost_empty_d = (count_d != {CW{1'b0}}) && (count_d <= AE_TH_C);
  end

  // State and registered outputs; reset wins over any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q       <= {ADDR_WIDTH{1'b0}};
      count_q        <= {CW{1'b0}};
      data_out_q     <= {DATA_WIDTH{1'b0}};
      valid_out_q    <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      valid_out_q    <= valid_out_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Storage array is not cleared by reset; stale words become unreachable
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;

endmodule
